axis_deskew: RTL and testbench
==============================

# axis_deskew

Output-side counterpart of the input skew delay line in the systolic array. The array emits R result lanes staggered in time: lane k carries its word k enabled cycles after lane 0. This block re-aligns the R lanes into one word and buffers aligned words in a FIFO. It presents the words as an AXI4-Stream master and throttles the array through a shared enable.

## Interface
Parameters:
- R, 4: number of lanes (≥1); lane k skewed by k cycles
- W, 8: lane data width in bits
- DEPTH, 8: output FIFO depth in words; power of two, ≥2

Ports:
- c  input  1  clock; all logic on rising edge
- r  input  1  reset, synchronous, active-high
- e  output  1  enable to array and this block's delay lines; shifting occurs only when e=1
- s_valid  input  1  word tag, aligned to lane 0 data
- s_last  input  1  end-of-packet tag, aligned to lane 0 data
- s_data  input  [R-1:0][W-1:0]  skewed lane data; lane k valid k enabled cycles after its tag
- m_axis_tvalid  output  1  AXI-Stream valid
- m_axis_tready  input  1  AXI-Stream ready
- m_axis_tdata  output  R*W  aligned word; lane k in bits [k*W +: W]
- m_axis_tlast  output  1  end-of-packet

## Operation
- Lane k passes through R-1-k register stages. Lane R-1 is combinational. Each stage loads only when e=1 and holds otherwise.
- s_valid/s_last pass through an R-1-stage tag pipeline with the same enable.
- Aligned word = {lane R-1 live input, lane k delay outputs}. Tag = tag pipeline output.
- FIFO push when e=1 and the delayed tag valid is 1. Pushed entry is {word, delayed last}.
- FIFO pop on m_axis_tvalid && m_axis_tready. tdata and tlast show the head entry, which is stable while tvalid=1 and tready=0.
- Occupancy count is in 0..DEPTH. Push and pop in the same cycle leave the count unchanged.
- e = !r && (count < DEPTH). It is derived from registered count only and has no combinational path from m_axis_tready.
- A push therefore never meets a full FIFO. e=0 freezes the delay lines, so no word in flight is lost or duplicated.
- Tags with s_valid=0 propagate as bubbles and cause no push.
- Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.

## Timing
- Reset (r=1 at an edge) clears all delay stages, tag pipeline, pointers and count.
- During and after reset: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, e=0 while r=1, e=1 the cycle after r falls.
- Reset mid-packet discards all in-flight and buffered words. No partial word is emitted afterwards.
- Latency with e held at 1:
  - Tag and lane 0 at cycle t, lane k at cycle t+k.
  - Push at the edge ending cycle t+R-1.
  - m_axis_tvalid=1 in cycle t+R.
  - R=1: push at the end of t, tvalid at t+1.
- If e drops for n cycles while a word is in flight, its push is delayed by exactly n cycles.
- Full FIFO (count=DEPTH): e=0 that cycle. A pop in that cycle raises e the next cycle.
- Empty FIFO: tvalid=0. A push into an empty FIFO shows tvalid the next cycle (no fall-through).
- Throughput: one word per cycle sustained when tready=1.

## Test plan
- Single word, R=4, W=8:
  - Stimulus: tag at t; lanes 0..3 = 0x11, 0x22, 0x33, 0x44 at t..t+3; tready=1.
  - Response: tvalid only in cycle t+4, tdata=0x44332211, tlast=0.
- Stream of 16 back-to-back words, tready=1:
  - Stimulus: s_last on word 15.
  - Response: 16 consecutive tvalid cycles, in order, tlast only on the 16th; e stays 1.
- Backpressure:
  - Stimulus: tready=0, DEPTH=8, 12 words offered.
  - Response: e falls the cycle count reaches 8. Raising tready yields all 12 words intact and in order; count never exceeds 8.
- Freeze mid-word:
  - Stimulus: FIFO near full forces e=0 for 3 cycles after lane 1 of a word arrives; the upstream model holds lanes while e=0.
  - Response: the word emerges 3 cycles later, uncorrupted.
- Reset mid-operation:
  - Stimulus: r=1 for 1 cycle with 5 words buffered and 2 in flight.
  - Response: next cycle tvalid=0, count=0, e=1. No stale word appears later.
- Bubbles and wrap:
  - Stimulus: alternating s_valid=1/0 for 40 cycles with random tready.
  - Response: only valid words are emitted, in order; pointers wrap at DEPTH without loss.

Source files
------------

// File: rtl/axis_deskew.sv
// axis_deskew: re-aligns R time-skewed result lanes from the systolic array
// into one word, buffers aligned words in a FIFO and presents them as an
// AXI4-Stream master. The shared enable e throttles the array so that a push
// never meets a full FIFO.
//
// Ports:
//   c              clock, all logic on rising edge
//   r              synchronous active-high reset
//   e              enable to array and internal delay lines
//   s_valid/s_last word tags, aligned to lane 0 data
//   s_data         skewed lane data, lane k arrives k enabled cycles after tag
//   m_axis_*       AXI4-Stream master (tdata lane k in bits [k*W +: W])
module axis_deskew #(
  parameter int unsigned R     = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                c,
  input  logic                r,
  output logic                e,
  input  logic                s_valid,
  input  logic                s_last,
  input  logic [R-1:0][W-1:0] s_data,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [R*W-1:0]      m_axis_tdata,
  output logic                m_axis_tlast
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [R*W-1:0] word;
  logic           tag_v;
  logic           tag_l;

  // Lane k is delayed by R-1-k enabled cycles; lane R-1 is used live.
  for (genvar k = 0; k < R - 1; k++) begin : g_lane
    localparam int unsigned N = R - 1 - k;
    logic [W-1:0] sr [N];

    always_ff @(posedge c) begin
      if (r) begin
        for (int unsigned i = 0; i < N; i++) sr[i] <= '0;
      end else if (e) begin
        sr[0] <= s_data[k];
        for (int unsigned i = 1; i < N; i++) sr[i] <= sr[i-1];
      end
    end

    assign word[k*W +: W] = sr[N-1];
  end

  assign word[(R-1)*W +: W] = s_data[R-1];

  // Tag pipeline matches the deepest lane delay (R-1 stages).
  if (R > 1) begin : g_tag
    logic tv [R-1];
    logic tl [R-1];

    always_ff @(posedge c) begin
      if (r) begin
        for (int unsigned i = 0; i < R - 1; i++) begin
          tv[i] <= 1'b0;
          tl[i] <= 1'b0;
        end
      end else if (e) begin
        tv[0] <= s_valid;
        tl[0] <= s_last;
        for (int unsigned i = 1; i < R - 1; i++) begin
          tv[i] <= tv[i-1];
          tl[i] <= tl[i-1];
        end
      end
    end

    assign tag_v = tv[R-2];
    assign tag_l = tl[R-2];
  end else begin : g_notag
    assign tag_v = s_valid;
    assign tag_l = s_last;
  end

  // Output FIFO
  logic [R*W:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          full;
  logic          push;
  logic          pop;
  logic [R*W:0]  head;

  // cnt never exceeds DEPTH (a power of two), so its MSB alone means full.
  assign full = cnt[AW];
  assign e    = !r && !full;
  assign push = e && tag_v;
  assign pop  = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge c) begin
    if (push) mem[wp] <= {tag_l, word};
  end

  always_ff @(posedge c) begin
    if (r) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head          = mem[rp];
  assign m_axis_tvalid = !r && (cnt != '0);
  // Data is forced to zero when nothing is valid so stale memory never shows.
  assign m_axis_tdata  = m_axis_tvalid ? head[R*W-1:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid && head[R*W];

endmodule

// File: tb/tb_axis_deskew.sv
// Self-checking bench for axis_deskew. Upstream is modelled as a sequence of
// word slots; the array advances one slot per enabled cycle and presents lane
// k of slot n-k. The reference FIFO is a queue of expected beats.
module tb_axis_deskew;
  localparam int R = 4;
  localparam int W = 8;
  localparam int DEPTH = 8;

  logic                c = 1'b0;
  logic                r;
  logic                e;
  logic                s_valid;
  logic                s_last;
  logic [R-1:0][W-1:0] s_data;
  logic                tvalid;
  logic                tready;
  logic [R*W-1:0]      tdata;
  logic                tlast;

  always #5 c = ~c;

  axis_deskew #(.R(R), .W(W), .DEPTH(DEPTH)) dut (
    .c(c), .r(r), .e(e),
    .s_valid(s_valid), .s_last(s_last), .s_data(s_data),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tdata(tdata), .m_axis_tlast(tlast)
  );

  typedef struct {
    bit                  v;
    bit                  l;
    logic [R-1:0][W-1:0] d;
  } slot_t;

  typedef struct {
    logic [R*W-1:0] d;
    bit             l;
  } beat_t;

  slot_t sl[$];
  beat_t sb[$];
  int n = 0;
  int base = 0;
  int nchk = 0;
  int nfail = 0;
  int beats = 0;
  int lasts = 0;
  int elow = 0;
  int cyc = 0;
  int last_pop_cyc = -1;
  logic [R*W-1:0] last_pop_data = '0;

  task automatic add(input bit v, input bit l, input logic [R*W-1:0] d);
    slot_t s;
    while (sl.size() < n) begin
      s.v = 0; s.l = 0; s.d = '0;
      sl.push_back(s);
    end
    s.v = v; s.l = l; s.d = d;
    sl.push_back(s);
  endtask

  task automatic drive();
    int m;
    if (n < sl.size()) begin
      s_valid = sl[n].v;
      s_last  = sl[n].l;
    end else begin
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
    for (int k = 0; k < R; k++) begin
      m = n - k;
      s_data[k] = (m >= 0 && m < sl.size()) ? sl[m].d[k] : '0;
    end
  endtask

  // One clock cycle: drive, check outputs mid-cycle against the model,
  // then advance the model to reflect the coming edge.
  task automatic tick();
    bit    exp_e;
    bit    exp_v;
    bit    popd;
    int    idx;
    beat_t b;
    drive();
    @(negedge c);
    exp_e = !r && (sb.size() < DEPTH);
    exp_v = !r && (sb.size() > 0);
    nchk++;
    if (e !== exp_e) begin
      nfail++;
      $display("FAIL enable cyc %0d: got %b want %b", cyc, e, exp_e);
    end
    nchk++;
    if (tvalid !== exp_v) begin
      nfail++;
      $display("FAIL tvalid cyc %0d: got %b want %b", cyc, tvalid, exp_v);
    end
    if (r) begin
      nchk++;
      if (tdata !== '0 || tlast !== 1'b0) begin
        nfail++;
        $display("FAIL reset_outputs cyc %0d: got tdata %h tlast %b want 0 0", cyc, tdata, tlast);
      end
    end
    popd = (tvalid === 1'b1) && (tready === 1'b1);
    if (popd) begin
      beats++;
      if (tlast === 1'b1) lasts++;
      last_pop_cyc = cyc;
      last_pop_data = tdata;
      if (sb.size() > 0) begin
        nchk++;
        if (tdata !== sb[0].d || tlast !== sb[0].l) begin
          nfail++;
          $display("FAIL beat cyc %0d: got %h/%b want %h/%b", cyc, tdata, tlast, sb[0].d, sb[0].l);
        end
      end
    end
    if (!r && e === 1'b0) elow++;
    if (r) begin
      sb.delete();
      base = n;
    end else begin
      if (exp_v && tready) void'(sb.pop_front());
      if (exp_e) begin
        idx = n - (R - 1);
        if (idx >= base && idx < sl.size() && sl[idx].v) begin
          b.d = sl[idx].d;
          b.l = sl[idx].l;
          sb.push_back(b);
        end
      end
    end
    if (!r && e === 1'b1) n++;
    cyc++;
    @(posedge c);
    #1;
  endtask

  task automatic test_reset();
    r = 1'b1;
    tready = 1'b0;
    tick();
    tick();
    nchk++;
    if (e !== 1'b0 || tvalid !== 1'b0) begin
      nfail++;
      $display("FAIL reset_hold: got e %b tvalid %b want 0 0", e, tvalid);
    end
    r = 1'b0;
    #1;
    nchk++;
    if (e !== 1'b1 || tvalid !== 1'b0) begin
      nfail++;
      $display("FAIL reset_release: got e %b tvalid %b want 1 0", e, tvalid);
    end
    tick();
  endtask

  task automatic test_single();
    int b0;
    int t0;
    tready = 1'b1;
    b0 = beats;
    add(1'b1, 1'b0, 32'h44332211);
    t0 = cyc;
    repeat (10) tick();
    nchk++;
    if (beats - b0 !== 1 || last_pop_cyc !== t0 + R || last_pop_data !== 32'h44332211) begin
      nfail++;
      $display("FAIL single: got %0d beats at cyc %0d data %h want 1 at %0d data 44332211",
               beats - b0, last_pop_cyc, last_pop_data, t0 + R);
    end
  endtask

  task automatic test_back_to_back();
    int b0;
    int l0;
    int e0;
    tready = 1'b1;
    b0 = beats; l0 = lasts; e0 = elow;
    for (int i = 0; i < 16; i++) add(1'b1, i == 15, $urandom);
    repeat (24) tick();
    nchk++;
    if (beats - b0 !== 16 || lasts - l0 !== 1 || elow !== e0) begin
      nfail++;
      $display("FAIL back_to_back: got beats %0d lasts %0d elow %0d want 16 1 0",
               beats - b0, lasts - l0, elow - e0);
    end
  endtask

  task automatic test_backpressure();
    int b0;
    int fall;
    tready = 1'b0;
    b0 = beats;
    fall = -1;
    for (int i = 0; i < 12; i++) add(1'b1, i == 11, $urandom);
    for (int i = 0; i < 20; i++) begin
      if (fall < 0 && e === 1'b0) fall = i;
      tick();
    end
    nchk++;
    if (fall !== DEPTH + R - 1) begin
      nfail++;
      $display("FAIL bp_efall: got cycle %0d want %0d", fall, DEPTH + R - 1);
    end
    nchk++;
    if (e !== 1'b0 || tvalid !== 1'b1) begin
      nfail++;
      $display("FAIL bp_full: got e %b tvalid %b want 0 1", e, tvalid);
    end
    tready = 1'b1;
    repeat (25) tick();
    nchk++;
    if (beats - b0 !== 12) begin
      nfail++;
      $display("FAIL bp_drain: got %0d beats want 12", beats - b0);
    end
  endtask

  task automatic test_freeze();
    int b0;
    int el0;
    int g;
    tready = 1'b0;
    b0 = beats;
    for (int i = 0; i < 9; i++) add(1'b1, i == 8, $urandom);
    g = 0;
    while (e === 1'b1 && g < 40) begin
      tick();
      g++;
    end
    nchk++;
    if (g >= 40) begin
      nfail++;
      $display("FAIL freeze_wait: got e still 1 after %0d cycles want 0", g);
    end
    el0 = elow;
    tick();
    tick();
    tready = 1'b1;
    tick();
    nchk++;
    if (elow - el0 !== 3 || e !== 1'b1) begin
      nfail++;
      $display("FAIL freeze_len: got %0d low cycles e %b want 3 1", elow - el0, e);
    end
    repeat (25) tick();
    nchk++;
    if (beats - b0 !== 9) begin
      nfail++;
      $display("FAIL freeze_drain: got %0d beats want 9", beats - b0);
    end
  endtask

  task automatic test_reset_mid();
    int b0;
    int g;
    tready = 1'b0;
    for (int i = 0; i < 7; i++) add(1'b1, i == 6, $urandom);
    g = 0;
    while (sb.size() < 5 && g < 40) begin
      tick();
      g++;
    end
    nchk++;
    if (g >= 40) begin
      nfail++;
      $display("FAIL rst_mid_wait: got %0d buffered want 5", sb.size());
    end
    r = 1'b1;
    tick();
    r = 1'b0;
    #1;
    nchk++;
    if (tvalid !== 1'b0 || e !== 1'b1) begin
      nfail++;
      $display("FAIL rst_mid: got tvalid %b e %b want 0 1", tvalid, e);
    end
    b0 = beats;
    tready = 1'b1;
    repeat (15) tick();
    nchk++;
    if (beats - b0 !== 0) begin
      nfail++;
      $display("FAIL rst_mid_stale: got %0d beats want 0", beats - b0);
    end
  endtask

  task automatic test_bubbles();
    int b0;
    b0 = beats;
    for (int i = 0; i < 40; i++) add(i % 2 == 0, $urandom_range(0, 1), $urandom);
    for (int i = 0; i < 40; i++) begin
      tready = $urandom_range(0, 1);
      tick();
    end
    tready = 1'b1;
    repeat (40) tick();
    nchk++;
    if (beats - b0 !== 20 || sb.size() !== 0) begin
      nfail++;
      $display("FAIL bubbles: got %0d beats %0d left want 20 0", beats - b0, sb.size());
    end
  endtask

  initial begin
    r = 1'b1;
    tready = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_data = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_freeze();
    test_reset_mid();
    test_bubbles();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
